text_mem_scheduler: RTL and testbench
=====================================

// Module: text_mem_scheduler
// PURPOSE
//  Owns the single write port and single read port of the 4096x8 text-cell RAM (1-cycle registered read).
//  Shares the write port between three users: host cell writes, a clear sweeper and a flush engine.
//  The flush engine reads every cell, streams it to the draw pipeline as a 24-bit command and zeroes it.
//  Sits between the command decoder (host side) and the text RAM / tile draw pipeline.
// PARAMETERS
//  COLS      43      cells per row; x counts 0..COLS-1
//  ROWS      24      rows; y counts 0..ROWS-1
//  CMD_A     8'd252  flush command opcode when flush_bank=0
//  CMD_B     8'd244  flush command opcode when flush_bank=1
// PORTS
//  clk        in   1   system clock
//  rst        in   1   reset, synchronous, active-high
//  hw_req     in   1   host write request; held until hw_ack
//  hw_x/hw_y  in   6/5 host cell coordinates
//  hw_data    in   8   host cell value
//  hw_ack     out  1   host write performed this cycle (combinational)
//  clear_go   in   1   start clear sweep (one-cycle pulse)
//  flush_go   in   1   start flush (one-cycle pulse)
//  flush_bank in   1   opcode select, sampled on flush_go
//  mem_waddr  out  12  {1'b0,x,y}
//  mem_w      out  1   RAM write enable
//  mem_wdata  out  8   RAM write data
//  mem_raddr  out  12  {1'b0,x,y}
//  mem_rdata  in   8   RAM read data, valid the cycle after mem_raddr
//  out_cmd    out  24  {opcode,8'd0,cell}
//  out_start  out  1   out_cmd valid (single-cycle strobe per cell)
//  busy       out  1   high in any state other than IDLE
//  done_irq   out  1   one-cycle pulse when clear or flush finishes
// BEHAVIOUR
//  - States: IDLE, CLEAR, FLUSH_RD, FLUSH_WR. Reset (sync) forces IDLE, x=y=0, bank=0, and all outputs 0.
//    hw_ack is also gated low while rst=1.
//  - IDLE: clear_go -> CLEAR. Otherwise flush_go -> FLUSH_RD, capturing the bank. Both set: clear wins, flush dropped.
//  - go pulses outside IDLE are ignored.
//  - CLEAR: writes 0 to (x,y) each cycle the engine holds the write port, then raster-advances.
//  - Raster advance: x wraps COLS-1 -> 0 with y+1. Leaving cell (COLS-1,ROWS-1) -> IDLE with done_irq=1 that cycle.
//  - CLEAR takes COLS*ROWS cycles when uncontended.
//  - FLUSH_RD: mem_raddr=(x,y); write port free -> FLUSH_WR.
//  - FLUSH_WR: out_cmd={opcode,8'd0,mem_rdata}, out_start=1, write 0 to (x,y), then advance.
//    After the last cell: IDLE + done_irq. Otherwise -> FLUSH_RD.
//  - Each flush cell takes 2 cycles; the full flush takes 2*COLS*ROWS cycles.
//  - Write priority (default): engine write over host. Host is acked in IDLE and in FLUSH_RD.
//    Host is stalled (hw_ack=0) in CLEAR and FLUSH_WR.
//  - Same-cycle host write to the cell in FLUSH_RD: write accepted, flush emits the old value, FLUSH_WR then zeroes it.
//  - Host write to an already-flushed or already-cleared cell survives.
//  - Unused outputs are 0 every cycle (mem_w=0, out_start=0, addresses 0).
// CONFIGURATION
//  TEXT_SCHED_RR_EN defined:
//    In CLEAR, with hw_req=1, grants alternate host/engine through a last-grant flag (reset: host-last).
//    A host-granted cycle does not advance the sweep, so CLEAR takes at most 2*COLS*ROWS cycles.
//    FLUSH behaviour is unchanged.
//  TEXT_SCHED_RR_EN undefined: fixed engine-over-host priority; the host can starve for a whole CLEAR.
// STRUCTURE
//  - Package text_mem_pkg: COLS, ROWS, CMD_A, CMD_B, state enum, and cell_addr(x,y) returning {1'b0,x,y}.
//  - Sub-module text_raster_counter: x/y counter with enable, wrap and a last-cell flag.
//    Its sync clear is rst or a go in IDLE.
// TESTING
//  1. IDLE, hw_req (x=5,y=3,data=8'h41) -> hw_ack same cycle; mem_w=1, mem_waddr=12'h0A3, mem_wdata=8'h41.
//  2. clear_go -> busy next cycle; 1032 consecutive mem_w=1 with mem_wdata=0.
//     Last write to 12'h557, done_irq one pulse, back in IDLE.
//     Held hw_req gets no ack until IDLE (default build).
//  3. RAM preloaded with (x+y), flush_go with flush_bank=1 -> 1032 out_start strobes, 2 cycles apart.
//     out_cmd = {8'd244,8'd0,x+y} in raster order; RAM all zero afterwards.
//  4. clear_go and flush_go in the same cycle -> clear only, exactly one done_irq.
//     flush_go during CLEAR is ignored.
//  5. rst asserted mid-flush at cell (10,4) -> next cycle IDLE, all outputs 0, no done_irq.
//     A new flush restarts at (0,0).
//  6. TEXT_SCHED_RR_EN build, hw_req held throughout CLEAR -> host acked every other cycle.
//     CLEAR length is 1032 engine writes plus the host cycles.

Source files
------------

// File: rtl/text_mem_scheduler_pkg.sv
// Shared constants, state encoding and address helper for the text-cell RAM scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package text_mem_pkg;

    localparam int COLS = 43;
    localparam int ROWS = 24;
    localparam int XW   = 6;
    localparam int YW   = 5;
    localparam int AW   = 12;

    localparam logic [7:0] CMD_A = 8'd252;
    localparam logic [7:0] CMD_B = 8'd244;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLEAR    = 2'd1,
        FLUSH_RD = 2'd2,
        FLUSH_WR = 2'd3
    } state_t;

    // RAM address of a cell: the top bit is unused by the 43x24 grid.
    function automatic logic [AW-1:0] cell_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return {1'b0, x, y};
    endfunction

endpackage

// File: rtl/text_mem_scheduler_if.sv
// Bus bundle between host/RAM/draw pipeline and the text RAM scheduler.
// Latency: n/a (wires only); mem_rdata is valid the cycle after mem_raddr.
// Backpressure: host write request is held until hw_ack; out_start has no backpressure.
//   Host side : hw_req, hw_x, hw_y, hw_data -> scheduler ; hw_ack <- scheduler
//   RAM side  : mem_waddr, mem_w, mem_wdata, mem_raddr <- scheduler ; mem_rdata -> scheduler
//   Draw side : out_cmd, out_start <- scheduler
interface text_mem_scheduler_if;

    logic        hw_req;
    logic [5:0]  hw_x;
    logic [4:0]  hw_y;
    logic [7:0]  hw_data;
    logic        hw_ack;

    logic [11:0] mem_waddr;
    logic        mem_w;
    logic [7:0]  mem_wdata;
    logic [11:0] mem_raddr;
    logic [7:0]  mem_rdata;

    logic [23:0] out_cmd;
    logic        out_start;

    // Environment view: host, RAM and draw pipeline together.
    modport master (
        output hw_req, hw_x, hw_y, hw_data, mem_rdata,
        input  hw_ack, mem_waddr, mem_w, mem_wdata, mem_raddr, out_cmd, out_start
    );

    // Scheduler view.
    modport slave (
        input  hw_req, hw_x, hw_y, hw_data, mem_rdata,
        output hw_ack, mem_waddr, mem_w, mem_wdata, mem_raddr, out_cmd, out_start
    );

endinterface

// File: rtl/text_mem_scheduler_raster_counter.sv
// Raster x/y cell counter for the clear sweep and flush engine.
// Latency: count updates on the clock edge after en; last is combinational from the count.
// Backpressure: none; the counter only moves when en is high.
//   clk, clr (sync clear to 0,0), en (advance one cell), x/y (current cell), last (at COLS-1,ROWS-1)
module text_raster_counter
    import text_mem_pkg::*;
(
    input  logic          clk,
    input  logic          clr,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    logic x_end;
    logic y_end;

    assign x_end = (x == XW'(COLS - 1));
    assign y_end = (y == YW'(ROWS - 1));
    assign last  = x_end && y_end;

    always_ff @(posedge clk) begin
        if (clr) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x_end) begin
                x <= '0;
                y <= y_end ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

endmodule

// File: rtl/text_mem_scheduler.sv
// Owns the text RAM ports; arbitrates host writes against a clear sweeper and a flush engine.
// Latency: host writes acked combinationally; clear 1 cycle/cell, flush 2 cycles/cell.
// Backpressure: hw_ack low while the engine owns the write port (CLEAR, FLUSH_WR).
//   Ports: clk, rst (sync, active-high), bus (slave modport: host write, RAM ports, draw command),
//          clear_go / flush_go / flush_bank (engine start), busy, done_irq.
//   Build option TEXT_SCHED_RR_EN: round-robin host/engine grants during CLEAR.
module text_mem_scheduler
    import text_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    text_mem_scheduler_if.slave   bus,
    input  logic                  clear_go,
    input  logic                  flush_go,
    input  logic                  flush_bank,
    output logic                  busy,
    output logic                  done_irq
);

    state_t        state;
    state_t        state_d;
    logic          bank;

    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic          clast;
    logic          adv;
    logic          go_idle;
    logic          host_grant;

    logic          ack_c;
    logic          w_c;
    logic [AW-1:0] waddr_c;
    logic [7:0]    wdata_c;
    logic [AW-1:0] raddr_c;
    logic [23:0]   cmd_c;
    logic          start_c;
    logic          done_c;

    // A go pulse only starts an engine from IDLE; it also rewinds the raster to (0,0).
    assign go_idle = (state == IDLE) && (clear_go || flush_go);

    text_raster_counter u_raster (
        .clk  (clk),
        .clr  (rst || go_idle),
        .en   (adv),
        .x    (cx),
        .y    (cy),
        .last (clast)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Bank is only captured when the flush really starts (clear wins a tie).
    always_ff @(posedge clk) begin
        if (rst) begin
            bank <= 1'b0;
        end else if (state == IDLE && flush_go && !clear_go) begin
            bank <= flush_bank;
        end
    end

`ifdef TEXT_SCHED_RR_EN
    // Last-grant flag for the CLEAR arbitration; 1 = host had the last grant.
    logic host_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            host_last <= 1'b1;
        end else if (state == CLEAR) begin
            host_last <= host_grant;
        end
    end
`endif

    always_comb begin
        state_d    = state;
        adv        = 1'b0;
        host_grant = 1'b0;
        ack_c      = 1'b0;
        w_c        = 1'b0;
        waddr_c    = '0;
        wdata_c    = '0;
        raddr_c    = '0;
        cmd_c      = '0;
        start_c    = 1'b0;
        done_c     = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.hw_req) begin
                    ack_c   = 1'b1;
                    w_c     = 1'b1;
                    waddr_c = cell_addr(bus.hw_x, bus.hw_y);
                    wdata_c = bus.hw_data;
                end
                if (clear_go) begin
                    state_d = CLEAR;
                end else if (flush_go) begin
                    state_d = FLUSH_RD;
                end
            end

            CLEAR: begin
`ifdef TEXT_SCHED_RR_EN
                host_grant = bus.hw_req && !host_last;
`endif
                if (host_grant) begin
                    // Host cycle: sweep holds its position.
                    ack_c   = 1'b1;
                    w_c     = 1'b1;
                    waddr_c = cell_addr(bus.hw_x, bus.hw_y);
                    wdata_c = bus.hw_data;
                end else begin
                    w_c     = 1'b1;
                    waddr_c = cell_addr(cx, cy);
                    wdata_c = 8'd0;
                    adv     = 1'b1;
                    if (clast) begin
                        state_d = IDLE;
                        done_c  = 1'b1;
                    end
                end
            end

            FLUSH_RD: begin
                // Write port is idle while the cell is read, so the host gets it.
                // A host write to this very cell lands after the read samples the old value.
                raddr_c = cell_addr(cx, cy);
                if (bus.hw_req) begin
                    ack_c   = 1'b1;
                    w_c     = 1'b1;
                    waddr_c = cell_addr(bus.hw_x, bus.hw_y);
                    wdata_c = bus.hw_data;
                end
                state_d = FLUSH_WR;
            end

            FLUSH_WR: begin
                cmd_c   = {(bank ? CMD_B : CMD_A), 8'd0, bus.mem_rdata};
                start_c = 1'b1;
                w_c     = 1'b1;
                waddr_c = cell_addr(cx, cy);
                wdata_c = 8'd0;
                adv     = 1'b1;
                if (clast) begin
                    state_d = IDLE;
                    done_c  = 1'b1;
                end else begin
                    state_d = FLUSH_RD;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Everything is forced quiet while reset is asserted, whatever the state register holds.
    assign bus.hw_ack    = ack_c & ~rst;
    assign bus.mem_w     = w_c & ~rst;
    assign bus.mem_waddr = rst ? '0 : waddr_c;
    assign bus.mem_wdata = rst ? '0 : wdata_c;
    assign bus.mem_raddr = rst ? '0 : raddr_c;
    assign bus.out_cmd   = rst ? '0 : cmd_c;
    assign bus.out_start = start_c & ~rst;
    assign busy          = (state != IDLE) & ~rst;
    assign done_irq      = done_c & ~rst;

endmodule

// File: tb/tb_text_mem_scheduler.sv
// Directed bench for text_mem_scheduler with a behavioural 4096x8 registered-read RAM.
// Latency: checks sample on the falling edge; inputs change 1 time unit after the rising edge.
// Backpressure: host request held until acked; bounded loops guard every engine run.
module tb_text_mem_scheduler;

    logic clk;
    logic rst;
    logic clear_go;
    logic flush_go;
    logic flush_bank;
    logic busy;
    logic done_irq;

    text_mem_scheduler_if bus();

    text_mem_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clear_go   (clear_go),
        .flush_go   (flush_go),
        .flush_bank (flush_bank),
        .busy       (busy),
        .done_irq   (done_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ram [4096];

    always @(posedge clk) begin
        if (bus.mem_w) ram[bus.mem_waddr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_raddr];
    end

    int n_vec;
    int n_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        req;
        logic [5:0]  x;
        logic [4:0]  y;
        logic [7:0]  d;
        logic        ack;
        logic        w;
        logic [11:0] waddr;
        logic [7:0]  wdata;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int cyc, ex, ey, writes, hosts, order, alt, dones, prev, fin;
        int strobes, cmd_err, gap_err, rd_err, last_cyc, ack_err, nz, busyc, found;
        logic [11:0] lastaddr;
        logic host_started, host_acked;

        n_vec = 0;
        n_bad = 0;

        vecs[0] = '{1'b1, 6'd5,  5'd3,  8'h41, 1'b1, 1'b1, 12'h0A3, 8'h41};
        vecs[1] = '{1'b0, 6'd5,  5'd3,  8'h41, 1'b0, 1'b0, 12'h000, 8'h00};
        vecs[2] = '{1'b1, 6'd0,  5'd0,  8'hFF, 1'b1, 1'b1, 12'h000, 8'hFF};
        vecs[3] = '{1'b1, 6'd42, 5'd23, 8'h7E, 1'b1, 1'b1, 12'h557, 8'h7E};
        vecs[4] = '{1'b1, 6'd1,  5'd0,  8'h01, 1'b1, 1'b1, 12'h020, 8'h01};
        vecs[5] = '{1'b1, 6'd0,  5'd1,  8'h02, 1'b1, 1'b1, 12'h001, 8'h02};
        vecs[6] = '{1'b1, 6'd20, 5'd10, 8'hAA, 1'b1, 1'b1, 12'h28A, 8'hAA};

        // Reset: a pending host request must not be acked while rst is high.
        rst = 1'b1; clear_go = 1'b0; flush_go = 1'b0; flush_bank = 1'b0;
        bus.hw_req = 1'b1; bus.hw_x = 6'd5; bus.hw_y = 5'd3; bus.hw_data = 8'h41;
        step(); step();
        @(negedge clk);
        chk("rst_hw_ack", bus.hw_ack, 0);
        chk("rst_mem_w", bus.mem_w, 0);
        chk("rst_busy", busy, 0);
        step();
        rst = 1'b0; bus.hw_req = 1'b0;
        step();

        // Host writes in IDLE.
        for (int i = 0; i < 7; i++) begin
            bus.hw_req = vecs[i].req; bus.hw_x = vecs[i].x;
            bus.hw_y = vecs[i].y; bus.hw_data = vecs[i].d;
            @(negedge clk);
            chk($sformatf("vec%0d_ack", i), bus.hw_ack, vecs[i].ack);
            chk($sformatf("vec%0d_w", i), bus.mem_w, vecs[i].w);
            chk($sformatf("vec%0d_waddr", i), bus.mem_waddr, vecs[i].waddr);
            chk($sformatf("vec%0d_wdata", i), bus.mem_wdata, vecs[i].wdata);
            step();
        end
        bus.hw_req = 1'b0;

        // Clear sweep with the host request held throughout.
        clear_go = 1'b1;
        @(negedge clk);
        chk("clear_go_cycle_busy", busy, 0);
        step();
        clear_go = 1'b0;
        bus.hw_req = 1'b1; bus.hw_x = 6'd1; bus.hw_y = 5'd1; bus.hw_data = 8'h55;
        ex = 0; ey = 0; cyc = 0; writes = 0; hosts = 0; order = 0; alt = 0;
        dones = 0; prev = -1; fin = 0; lastaddr = '0;
        while (!fin && cyc < 2200) begin
            @(negedge clk);
            cyc++;
            if (!busy) order++;
            if (bus.hw_ack) begin
                hosts++;
                if (prev == 1) alt++;
                prev = 1;
            end else begin
                if (bus.mem_w && bus.mem_wdata == 8'd0 && bus.mem_waddr == {1'b0, 6'(ex), 5'(ey)}) begin
                    writes++;
                    lastaddr = bus.mem_waddr;
                    if (ex == 42) begin ex = 0; ey = (ey == 23) ? 0 : ey + 1; end
                    else ex++;
                end else begin
                    order++;
                end
`ifdef TEXT_SCHED_RR_EN
                if (prev == 0) alt++;
`endif
                prev = 0;
            end
            if (done_irq) begin dones++; fin = 1; end
            step();
        end
        chk("clear_writes", writes, 1032);
        chk("clear_order", order, 0);
        chk("clear_last_addr", lastaddr, 12'h557);
        chk("clear_done", dones, 1);
        chk("clear_alternation", alt, 0);
`ifdef TEXT_SCHED_RR_EN
        chk("clear_host_acks", hosts, 1031);
        chk("clear_cycles", cyc, 2063);
`else
        chk("clear_host_acks", hosts, 0);
        chk("clear_cycles", cyc, 1032);
`endif
        @(negedge clk);
        chk("after_clear_busy", busy, 0);
        chk("after_clear_ack", bus.hw_ack, 1);
        chk("after_clear_done", done_irq, 0);
        step();
        bus.hw_req = 1'b0;

        // Preload RAM with x+y through host writes.
        for (int y = 0; y < 24; y++) begin
            for (int x = 0; x < 43; x++) begin
                bus.hw_req = 1'b1; bus.hw_x = 6'(x); bus.hw_y = 5'(y); bus.hw_data = 8'(x + y);
                step();
            end
        end
        bus.hw_req = 1'b0;

        // Flush on bank 1; host rewrites an already-flushed cell mid-run.
        flush_go = 1'b1; flush_bank = 1'b1;
        step();
        flush_go = 1'b0; flush_bank = 1'b0;
        ex = 0; ey = 0; cyc = 0; strobes = 0; cmd_err = 0; gap_err = 0; rd_err = 0;
        last_cyc = 0; ack_err = 0; dones = 0; fin = 0;
        host_started = 1'b0; host_acked = 1'b0;
        while (!fin && cyc < 2300) begin
            @(negedge clk);
            cyc++;
            if (bus.out_start) begin
                if (bus.out_cmd !== {8'd244, 8'd0, 8'(ex + ey)}) cmd_err++;
                if (strobes > 0 && cyc - last_cyc != 2) gap_err++;
                last_cyc = cyc;
                strobes++;
                if (ex == 42) begin ex = 0; ey = (ey == 23) ? 0 : ey + 1; end
                else ex++;
                if (bus.hw_ack) ack_err++;
            end else if (bus.mem_raddr !== {1'b0, 6'(ex), 5'(ey)}) begin
                rd_err++;
            end
            if (bus.hw_ack) host_acked = 1'b1;
            if (done_irq) begin dones++; fin = 1; end
            step();
            if (host_acked) begin
                bus.hw_req = 1'b0;
            end else if (strobes == 100 && !host_started) begin
                bus.hw_req = 1'b1; bus.hw_x = 6'd0; bus.hw_y = 5'd0; bus.hw_data = 8'h99;
                host_started = 1'b1;
            end
        end
        bus.hw_req = 1'b0;
        chk("flush_strobes", strobes, 1032);
        chk("flush_cmd", cmd_err, 0);
        chk("flush_gap", gap_err, 0);
        chk("flush_raddr", rd_err, 0);
        chk("flush_done", dones, 1);
        chk("flush_cycles", cyc, 2064);
        chk("flush_host_acked", host_acked, 1);
        chk("flush_host_stall_wr", ack_err, 0);
        @(negedge clk);
        chk("after_flush_busy", busy, 0);
        nz = 0;
        for (int y = 0; y < 24; y++)
            for (int x = 0; x < 43; x++)
                if ((x != 0 || y != 0) && ram[{1'b0, 6'(x), 5'(y)}] !== 8'd0) nz++;
        chk("flush_ram_zero", nz, 0);
        chk("flush_host_survives", ram[0], 8'h99);
        step();

        // clear_go and flush_go together, plus flush_go mid-clear.
        clear_go = 1'b1; flush_go = 1'b1; flush_bank = 1'b1;
        step();
        clear_go = 1'b0; flush_go = 1'b0;
        busyc = 0; dones = 0; strobes = 0;
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk);
            if (busy) busyc++;
            if (done_irq) dones++;
            if (bus.out_start) strobes++;
            step();
            flush_go = (c == 9);
        end
        chk("tie_busy_cycles", busyc, 1032);
        chk("tie_done", dones, 1);
        chk("tie_no_flush", strobes, 0);
        @(negedge clk);
        chk("tie_idle", busy, 0);
        step();

        // Reset in the middle of a flush at cell (10,4).
        flush_go = 1'b1; flush_bank = 1'b0;
        step();
        flush_go = 1'b0;
        found = 0;
        for (int c = 0; c < 1000 && found == 0; c++) begin
            @(negedge clk);
            if (bus.mem_raddr == 12'h144) found = 1;
            else step();
        end
        chk("midflush_reached", found, 1);
        rst = 1'b1;
        #1;
        chk("rst_cycle_done", done_irq, 0);
        chk("rst_cycle_raddr", bus.mem_raddr, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_mem_w", bus.mem_w, 0);
        chk("post_rst_start", bus.out_start, 0);
        chk("post_rst_done", done_irq, 0);
        chk("post_rst_cmd", bus.out_cmd, 0);
        step();
        flush_go = 1'b1;
        step();
        flush_go = 1'b0;
        @(negedge clk);
        chk("restart_busy", busy, 1);
        chk("restart_raddr", bus.mem_raddr, 12'h000);
        step();
        @(negedge clk);
        chk("restart_start", bus.out_start, 1);
        chk("restart_opcode", bus.out_cmd[23:16], 8'd252);
        step();
        rst = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
